// File: rtl/select_encode_seq.sv
// select_encode_seq: registered register-select/encode stage between the
// control unit and the GPR file. Keeps a private IR copy, decodes ra/rb/rc
// into one-hot in/out enables, handles the R0 base-address override, raises
// a sticky error on illegal selects, and runs an ra->rb->rc output scan.
module select_encode_seq #(
    parameter int NUM_REGS = 16,
    parameter int REG_W    = 4,
    parameter int C_W      = 19
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic                ir_load,
    input  logic [31:0]         ir_in,
    input  logic                Gra,
    input  logic                Grb,
    input  logic                Grc,
    input  logic                r_in,
    input  logic                r_out,
    input  logic                ba_out,
    input  logic                scan_start,
    output logic [NUM_REGS-1:0] sel_in,
    output logic [NUM_REGS-1:0] sel_out,
    output logic                ba_zero,
    output logic [31:0]         c_sign,
    output logic [4:0]          opcode,
    output logic                scan_busy,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_SA, S_SB, S_SC} state_e;

    // Register count widened by one bit so NUM_REGS == 2^REG_W still fits.
    localparam logic [REG_W:0] NREG = (REG_W+1)'(NUM_REGS);

    state_e              state_q, state_d;
    logic [31:0]         ir_q;
    logic [NUM_REGS-1:0] sel_in_q, sel_in_d;
    logic [NUM_REGS-1:0] sel_out_q, sel_out_d;
    logic                ba_zero_q, ba_zero_d;
    logic                busy_q;
    logic                err_q, err_d;

    logic [REG_W-1:0]    ra, rb, rc, idx;
    logic                ga, gb, gc, any_g, multi_g;
    logic                wr, rd, ba, en, in_range, valid;
    logic [NUM_REGS-1:0] onehot;

    assign ra = ir_q[26 -: REG_W];
    assign rb = ir_q[26-REG_W -: REG_W];
    assign rc = ir_q[26-2*REG_W -: REG_W];

    // Field select, enable steering, decode and error/next-state logic.
    always_comb begin
        state_d   = state_q;
        ga        = 1'b0;
        gb        = 1'b0;
        gc        = 1'b0;
        wr        = 1'b0;
        rd        = 1'b0;
        ba        = 1'b0;
        idx       = '0;
        sel_in_d  = '0;
        sel_out_d = '0;
        ba_zero_d = 1'b0;

        // While scanning, the sequencer owns the select and acts as r_out.
        unique case (state_q)
            S_IDLE: begin
                ga = Gra; gb = Grb; gc = Grc;
                wr = r_in; rd = r_out; ba = ba_out;
                if (scan_start) state_d = S_SA;
            end
            S_SA: begin ga = 1'b1; rd = 1'b1; state_d = S_SB;   end
            S_SB: begin gb = 1'b1; rd = 1'b1; state_d = S_SC;   end
            S_SC: begin gc = 1'b1; rd = 1'b1; state_d = S_IDLE; end
            default: state_d = S_IDLE;
        endcase

        any_g   = ga | gb | gc;
        multi_g = (ga & gb) | (ga & gc) | (gb & gc);
        if (ga)      idx = ra;
        else if (gb) idx = rb;
        else if (gc) idx = rc;

        in_range = ({1'b0, idx} < NREG);
        valid    = any_g & in_range;
        onehot   = valid ? (NUM_REGS'(1) << idx) : '0;
        en       = wr | rd | ba;

        if (wr) begin
            sel_in_d = onehot;
        end else if ((rd | ba) && valid) begin
            // Base-address read of R0 means the bus carries a literal zero.
            if (ba && idx == '0) ba_zero_d = 1'b1;
            else                 sel_out_d = onehot;
        end

        err_d = err_q | (en & (multi_g | (any_g & ~in_range)));
    end

    // FSM, IR and all registered outputs.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            sel_in_q  <= '0;
            sel_out_q <= '0;
            ba_zero_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (ir_load) ir_q <= ir_in;
            sel_in_q  <= sel_in_d;
            sel_out_q <= sel_out_d;
            ba_zero_q <= ba_zero_d;
            busy_q    <= (state_q != S_IDLE);
            err_q     <= err_d;
        end
    end

    assign sel_in    = sel_in_q;
    assign sel_out   = sel_out_q;
    assign ba_zero   = ba_zero_q;
    assign scan_busy = busy_q;
    assign err       = err_q;
    assign opcode    = ir_q[31:27];
    assign c_sign    = {{(32-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

endmodule

// File: tb/tb_select_encode_seq.sv
// Directed bench for select_encode_seq: a 16-register instance and an
// 8-register instance share all inputs; expectations are hand-computed.
module tb_select_encode_seq;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        ir_load;
    logic [31:0] ir_in;
    logic        Gra, Grb, Grc, r_in, r_out, ba_out, scan_start;

    logic [15:0] sel_in, sel_out;
    logic        ba_zero, scan_busy, err;
    logic [31:0] c_sign;
    logic [4:0]  opcode;

    logic [7:0]  sel_in8, sel_out8;
    logic        ba_zero8, scan_busy8, err8;
    logic [31:0] c_sign8;
    logic [4:0]  opcode8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    select_encode_seq #(.NUM_REGS(16), .REG_W(4), .C_W(19)) dut (
        .clock(clock), .clear_n(clear_n), .ir_load(ir_load), .ir_in(ir_in),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .r_in(r_in), .r_out(r_out),
        .ba_out(ba_out), .scan_start(scan_start),
        .sel_in(sel_in), .sel_out(sel_out), .ba_zero(ba_zero), .c_sign(c_sign),
        .opcode(opcode), .scan_busy(scan_busy), .err(err));

    select_encode_seq #(.NUM_REGS(8), .REG_W(4), .C_W(19)) dut8 (
        .clock(clock), .clear_n(clear_n), .ir_load(ir_load), .ir_in(ir_in),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .r_in(r_in), .r_out(r_out),
        .ba_out(ba_out), .scan_start(scan_start),
        .sel_in(sel_in8), .sel_out(sel_out8), .ba_zero(ba_zero8), .c_sign(c_sign8),
        .opcode(opcode8), .scan_busy(scan_busy8), .err(err8));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ctl_idle();
        Gra = 0; Grb = 0; Grc = 0; r_in = 0; r_out = 0; ba_out = 0;
        scan_start = 0; ir_load = 0;
    endtask

    task automatic do_reset();
        ctl_idle();
        clear_n = 0;
        step();
        clear_n = 1;
        step();
    endtask

    task automatic load_ir(input logic [31:0] v);
        ir_in = v; ir_load = 1;
        step();
        ir_load = 0;
    endtask

    task automatic test_reset();
        ctl_idle();
        ir_in = 32'hFFFF_FFFF;
        clear_n = 0;
        #3;
        vectors++; if (sel_in !== 16'h0) begin miscompares++; $display("FAIL reset_sel_in got %h exp 0000", sel_in); end
        vectors++; if (sel_out !== 16'h0) begin miscompares++; $display("FAIL reset_sel_out got %h exp 0000", sel_out); end
        vectors++; if ({ba_zero, scan_busy, err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b exp 000", {ba_zero, scan_busy, err}); end
        vectors++; if (c_sign !== 32'h0 || opcode !== 5'h0) begin miscompares++; $display("FAIL reset_ir got c=%h op=%h exp 0/0", c_sign, opcode); end
        step();
        clear_n = 1;
        step();
    endtask

    task automatic test_write();
        do_reset();
        load_ir(32'h0A88_0000);
        vectors++; if (opcode !== 5'h01 || c_sign !== 32'h0) begin miscompares++; $display("FAIL write_ir_fields got op=%h c=%h exp 01/0", opcode, c_sign); end
        Gra = 1; r_in = 1;
        step();
        vectors++; if (sel_in !== 16'h0020 || sel_out !== 16'h0) begin miscompares++; $display("FAIL write_sel got in=%h out=%h exp 0020/0000", sel_in, sel_out); end
        Gra = 0; r_in = 0;
        step();
        vectors++; if (sel_in !== 16'h0) begin miscompares++; $display("FAIL write_one_cycle got %h exp 0000", sel_in); end
        // Decode on the capture edge still sees the old IR (ra=5), then ra=3.
        Gra = 1; r_in = 1; ir_in = 32'h0180_0000; ir_load = 1;
        step();
        ir_load = 0;
        vectors++; if (sel_in !== 16'h0020) begin miscompares++; $display("FAIL write_old_ir got %h exp 0020", sel_in); end
        step();
        vectors++; if (sel_in !== 16'h0008) begin miscompares++; $display("FAIL write_new_ir got %h exp 0008", sel_in); end
        ctl_idle();
        step();
    endtask

    task automatic test_priority_err();
        do_reset();
        load_ir(32'h0A88_0000);
        Gra = 1; Grb = 1; r_out = 1;
        step();
        vectors++; if (sel_out !== 16'h0020 || err !== 1'b1) begin miscompares++; $display("FAIL prio_ra_wins got out=%h err=%b exp 0020/1", sel_out, err); end
        ctl_idle();
        step(); step();
        vectors++; if (err !== 1'b1 || sel_out !== 16'h0) begin miscompares++; $display("FAIL prio_err_sticky got err=%b out=%h exp 1/0000", err, sel_out); end
        // Multiple G with no enable is harmless.
        do_reset();
        Gra = 1; Grb = 1; Grc = 1;
        step();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL prio_no_en_no_err got %b exp 0", err); end
        ctl_idle();
        clear_n = 0; #1;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL prio_err_cleared got %b exp 0", err); end
        clear_n = 1;
        step();
    endtask

    task automatic test_base_addr();
        do_reset();
        load_ir(32'h0010_0000); // ra=0, rb=2
        Gra = 1; ba_out = 1;
        step();
        vectors++; if (sel_out !== 16'h0 || ba_zero !== 1'b1) begin miscompares++; $display("FAIL ba_r0 got out=%h bz=%b exp 0000/1", sel_out, ba_zero); end
        ba_out = 0; r_out = 1;
        step();
        vectors++; if (sel_out !== 16'h0001 || ba_zero !== 1'b0) begin miscompares++; $display("FAIL ba_rout_r0 got out=%h bz=%b exp 0001/0", sel_out, ba_zero); end
        Gra = 0; Grb = 1; r_out = 0; ba_out = 1;
        step();
        vectors++; if (sel_out !== 16'h0004 || ba_zero !== 1'b0) begin miscompares++; $display("FAIL ba_rb got out=%h bz=%b exp 0004/0", sel_out, ba_zero); end
        Grb = 0; Gra = 1; r_in = 1;
        step();
        vectors++; if (sel_in !== 16'h0001 || sel_out !== 16'h0 || ba_zero !== 1'b0) begin miscompares++; $display("FAIL ba_rin_prio got in=%h out=%h bz=%b exp 0001/0000/0", sel_in, sel_out, ba_zero); end
        ctl_idle();
        step();
        vectors++; if ({sel_in, sel_out, ba_zero} !== 33'h0) begin miscompares++; $display("FAIL ba_idle got in=%h out=%h bz=%b exp 0", sel_in, sel_out, ba_zero); end
    endtask

    task automatic test_sign();
        do_reset();
        load_ir(32'h0004_0000);
        vectors++; if (c_sign !== 32'hFFFC_0000) begin miscompares++; $display("FAIL sign_neg got %h exp FFFC0000", c_sign); end
        load_ir(32'h0003_FFFF);
        vectors++; if (c_sign !== 32'h0003_FFFF) begin miscompares++; $display("FAIL sign_pos got %h exp 0003FFFF", c_sign); end
        load_ir(32'hF800_0000);
        vectors++; if (opcode !== 5'h1F || c_sign !== 32'h0) begin miscompares++; $display("FAIL sign_opcode got op=%h c=%h exp 1F/0", opcode, c_sign); end
    endtask

    task automatic test_scan();
        do_reset();
        load_ir(32'h01BF_8000); // ra=3, rb=7, rc=15
        scan_start = 1;
        step(); // edge N
        scan_start = 0;
        vectors++; if (scan_busy !== 1'b0 || sel_out !== 16'h0) begin miscompares++; $display("FAIL scan_n got busy=%b out=%h exp 0/0000", scan_busy, sel_out); end
        Grb = 1; r_in = 1;
        step(); // N+1
        vectors++; if (sel_out !== 16'h0008 || sel_in !== 16'h0 || scan_busy !== 1'b1) begin miscompares++; $display("FAIL scan_ra got out=%h in=%h busy=%b exp 0008/0000/1", sel_out, sel_in, scan_busy); end
        vectors++; if (sel_out8 !== 8'h08) begin miscompares++; $display("FAIL scan8_ra got %h exp 08", sel_out8); end
        scan_start = 1;
        step(); // N+2, scan_start seen in SB is ignored
        scan_start = 0;
        vectors++; if (sel_out !== 16'h0080 || sel_in !== 16'h0 || scan_busy !== 1'b1) begin miscompares++; $display("FAIL scan_rb got out=%h in=%h busy=%b exp 0080/0000/1", sel_out, sel_in, scan_busy); end
        ctl_idle();
        step(); // N+3
        vectors++; if (sel_out !== 16'h8000 || scan_busy !== 1'b1) begin miscompares++; $display("FAIL scan_rc got out=%h busy=%b exp 8000/1", sel_out, scan_busy); end
        vectors++; if (sel_out8 !== 8'h00 || err8 !== 1'b1) begin miscompares++; $display("FAIL scan8_rc_oor got out=%h err=%b exp 00/1", sel_out8, err8); end
        step(); // N+4
        vectors++; if (scan_busy !== 1'b0 || sel_out !== 16'h0 || err !== 1'b0) begin miscompares++; $display("FAIL scan_done got busy=%b out=%h err=%b exp 0/0000/0", scan_busy, sel_out, err); end
        step();
        vectors++; if (scan_busy !== 1'b0) begin miscompares++; $display("FAIL scan_no_restart got %b exp 0", scan_busy); end
    endtask

    task automatic test_scan_ir_load();
        do_reset();
        load_ir(32'h01BF_8000);
        scan_start = 1;
        step(); // N
        scan_start = 0;
        ir_in = 32'h0012_0000; ir_load = 1; // rb=2, rc=4 take effect for SB/SC
        step(); // N+1 shows old ra=3
        ir_load = 0;
        vectors++; if (sel_out !== 16'h0008) begin miscompares++; $display("FAIL scanld_ra got %h exp 0008", sel_out); end
        step();
        vectors++; if (sel_out !== 16'h0004) begin miscompares++; $display("FAIL scanld_rb got %h exp 0004", sel_out); end
        step();
        vectors++; if (sel_out !== 16'h0010) begin miscompares++; $display("FAIL scanld_rc got %h exp 0010", sel_out); end
        step();
    endtask

    task automatic test_oor();
        do_reset();
        load_ir(32'h0480_0000); // ra=9
        Gra = 1; r_out = 1;
        step();
        vectors++; if (sel_out8 !== 8'h00 || err8 !== 1'b1) begin miscompares++; $display("FAIL oor8 got out=%h err=%b exp 00/1", sel_out8, err8); end
        vectors++; if (sel_out !== 16'h0200 || err !== 1'b0) begin miscompares++; $display("FAIL oor16 got out=%h err=%b exp 0200/0", sel_out, err); end
        ctl_idle();
        step();
    endtask

    task automatic test_midscan_reset();
        do_reset();
        load_ir(32'h01BF_8000);
        scan_start = 1;
        step();
        scan_start = 0;
        step(); // N+1
        vectors++; if (scan_busy !== 1'b1 || sel_out !== 16'h0008) begin miscompares++; $display("FAIL mid_pre got busy=%b out=%h exp 1/0008", scan_busy, sel_out); end
        clear_n = 0;
        #1;
        vectors++; if (scan_busy !== 1'b0 || sel_out !== 16'h0 || sel_in !== 16'h0 || ba_zero !== 1'b0) begin miscompares++; $display("FAIL mid_async got busy=%b out=%h in=%h bz=%b exp 0", scan_busy, sel_out, sel_in, ba_zero); end
        vectors++; if (c_sign !== 32'h0 || opcode !== 5'h0 || err !== 1'b0 || err8 !== 1'b0) begin miscompares++; $display("FAIL mid_async_ir got c=%h op=%h err=%b err8=%b exp 0", c_sign, opcode, err, err8); end
        step();
        clear_n = 1;
        step(); step();
        vectors++; if (scan_busy !== 1'b0 || sel_out !== 16'h0) begin miscompares++; $display("FAIL mid_aborted got busy=%b out=%h exp 0/0000", scan_busy, sel_out); end
    endtask

    initial begin
        ctl_idle();
        ir_in = '0;
        clear_n = 1;
        #2;
        test_reset();
        test_write();
        test_priority_err();
        test_base_addr();
        test_sign();
        test_scan();
        test_scan_ir_load();
        test_oor();
        test_midscan_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
